// File: rtl/wta_disparity_select.sv
// ============================================================================
// Module   : wta_disparity_select
// Brief    : Winner-take-all disparity picker; strict-min over streamed SAD costs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wta_disparity_select #(
  parameter int unsigned COST_WIDTH = 5,
  parameter int unsigned MAX_DISP   = 16,
  parameter int unsigned DISP_WIDTH = $clog2(MAX_DISP)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [COST_WIDTH-1:0] cost_in,
  input  logic                  cost_valid_in,
  input  logic                  cost_last_in,
  output logic                  cost_ready_out,
  output logic [DISP_WIDTH-1:0] disp_out,
  output logic [COST_WIDTH-1:0] min_cost_out,
  output logic                  disp_valid_out,
  input  logic                  disp_ready_in,
  output logic                  overflow_out
);

  localparam logic [0:0]            C_SCAN     = 1'b0;
  localparam logic [0:0]            C_OUT      = 1'b1;
  localparam logic [DISP_WIDTH-1:0] C_LAST_IDX = DISP_WIDTH'(MAX_DISP - 1);
  localparam logic [DISP_WIDTH-1:0] C_ONE      = DISP_WIDTH'(1);

  logic [0:0]            state_q, state_d;
  logic                  live_q;
  logic [DISP_WIDTH-1:0] idx_q, idx_d;
  logic [COST_WIDTH-1:0] best_cost_q, best_cost_d;
  logic [DISP_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [DISP_WIDTH-1:0] disp_q, disp_d;
  logic [COST_WIDTH-1:0] min_cost_q, min_cost_d;
  logic                  ovf_q, ovf_d;

  logic                  xfer;
  logic                  take;
  logic                  at_cap;
  logic                  terminal;
  logic [COST_WIDTH-1:0] cand_cost;
  logic [DISP_WIDTH-1:0] cand_idx;

  // live_q holds off the first accept until a clock edge follows reset release
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= C_SCAN;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_SCAN:  if (terminal) state_d = C_OUT;
      C_OUT:   if (disp_ready_in) state_d = C_SCAN;
      default: state_d = C_SCAN;
    endcase
  end

  always_comb begin
    cost_ready_out = (state_q == C_SCAN) && live_q;
    disp_valid_out = (state_q == C_OUT);
    disp_out       = disp_q;
    min_cost_out   = min_cost_q;
    overflow_out   = ovf_q;
  end

  // Winner including the cost on the bus; ties keep the earlier disparity
  assign xfer      = cost_valid_in && cost_ready_out;
  assign take      = (idx_q == '0) || (cost_in < best_cost_q);
  assign cand_cost = take ? cost_in : best_cost_q;
  assign cand_idx  = take ? idx_q : best_idx_q;
  assign at_cap    = (idx_q == C_LAST_IDX);
  assign terminal  = xfer && (cost_last_in || at_cap);

  always_comb begin
    idx_d       = idx_q;
    best_cost_d = best_cost_q;
    best_idx_d  = best_idx_q;
    disp_d      = disp_q;
    min_cost_d  = min_cost_q;
    ovf_d       = 1'b0;
    if (xfer) begin
      best_cost_d = cand_cost;
      best_idx_d  = cand_idx;
      if (terminal) begin
        idx_d      = '0;
        disp_d     = cand_idx;
        min_cost_d = cand_cost;
        ovf_d      = at_cap && !cost_last_in;
      end else begin
        idx_d = idx_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx_q       <= '0;
      best_cost_q <= '0;
      best_idx_q  <= '0;
      disp_q      <= '0;
      min_cost_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      best_cost_q <= best_cost_d;
      best_idx_q  <= best_idx_d;
      disp_q      <= disp_d;
      min_cost_q  <= min_cost_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/wta_disparity_select.md
Name: wta_disparity_select

Overview:
- Winner-take-all stage downstream of the 5-bit SAD cost comparator in the depth pipeline.
- Consumes one SAD cost per disparity candidate for a pixel, streamed in increasing disparity order (d = 0, 1, 2, ...).
- Tracks the running minimum with a strict less-than compare and emits the winning disparity plus its cost per pixel over a valid/ready handshake.
- Feeds the depth-map writer.

Parameters:
- COST_WIDTH, 5: bit width of each SAD cost; matches the comparator operand width.
- MAX_DISP, 16: maximum number of disparity candidates per pixel; must be >= 2.
- DISP_WIDTH, $clog2(MAX_DISP): width of the disparity index.

Ports:
- clk_in  input  1  system clock; all state is updated on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset. One clock, clk_in; reset asynchronous and active-low.
- cost_in  input  COST_WIDTH  unsigned SAD cost for the current candidate.
- cost_valid_in  input  1  cost_in is valid.
- cost_last_in  input  1  marks the final candidate of the current pixel.
- cost_ready_out  output  1  block can accept a cost this cycle.
- disp_out  output  DISP_WIDTH  winning disparity index.
- min_cost_out  output  COST_WIDTH  cost at the winning disparity.
- disp_valid_out  output  1  disp_out and min_cost_out are valid.
- disp_ready_in  input  1  downstream accepts the result.
- overflow_out  output  1  one-cycle pulse: a pixel was force-terminated at MAX_DISP candidates.

Behaviour:
- Reset (rst_n_in low, asynchronous assert): state SCAN, counter idx = 0, best_cost = 0, best_idx = 0.
  - Output reset values: cost_ready_out = 0, disp_valid_out = 0, disp_out = 0, min_cost_out = 0, overflow_out = 0.
  - Deassert is sampled on clk_in; cost_ready_out rises on the first rising edge after release.
- A cost transfer occurs on a rising edge with cost_valid_in && cost_ready_out.
- SCAN state: cost_ready_out = 1, disp_valid_out = 0. On each transfer:
  - If idx == 0: best_cost <= cost_in, best_idx <= 0 (unconditional initialise).
  - Else if cost_in < best_cost (unsigned, strict): best_cost <= cost_in, best_idx <= idx. Ties keep the earlier, lower disparity.
  - If cost_last_in == 1 or idx == MAX_DISP-1, the transfer is terminal:
    - Go to OUT.
    - idx <= 0.
    - disp_out and min_cost_out take the final winner, including the current cost if it won.
    - disp_valid_out = 1 on the next cycle.
  - Otherwise idx <= idx + 1.
- Forced termination: idx == MAX_DISP-1 with cost_last_in == 0 still terminates the pixel. overflow_out pulses high for exactly the cycle in which disp_valid_out first rises.
- Latency: the result is valid 1 cycle after the terminal cost transfer.
- OUT state:
  - cost_ready_out = 0. Costs presented in this state are not consumed, and idx, best_cost and best_idx do not change.
  - disp_out, min_cost_out and disp_valid_out stay stable until disp_valid_out && disp_ready_in.
  - On that handshake: go to SCAN; disp_valid_out = 0 and cost_ready_out = 1 on the next cycle. There is no bubble beyond that one turnaround cycle.
- disp_ready_in has no effect in SCAN. cost_last_in is ignored when cost_valid_in is low.
- Single-candidate pixel (cost_last_in on the first transfer): disp_out = 0, min_cost_out = that cost.
- Reset mid-pixel or mid-OUT: the partial result is discarded, all outputs return to their reset values, and no disp_valid_out is produced for the aborted pixel.
- All arithmetic is unsigned. idx never exceeds MAX_DISP-1 and has no wrap-around path.

Test Plan:
- Reset, then stream costs [20, 9, 14, 9, 31], last on the 5th, disp_ready_in = 1 -> one cycle later disp_valid_out = 1, disp_out = 1, min_cost_out = 9 (tie at d = 3 rejected); cost_ready_out = 1 again on the following cycle.
- Single cost 7 with cost_last_in = 1 -> disp_out = 0, min_cost_out = 7, overflow_out = 0.
- Hold disp_ready_in = 0 for 5 cycles in OUT while cost_valid_in = 1, cost_in = 0 -> cost_ready_out = 0, outputs stable, no cost consumed; release -> next pixel starts at idx = 0 with its own first cost.
- 16 costs descending 31..16, cost_last_in never high (MAX_DISP = 16) -> forced terminal at the 16th cost; disp_out = 15, min_cost_out = 16, overflow_out pulses for 1 cycle.
- Back-to-back pixels [3, 1, 2] then [0, 5], cost_valid_in held high throughout, disp_ready_in = 1 -> results (d = 1, cost 1) then (d = 0, cost 0); there is no cost loss and no duplication.
- Assert rst_n_in low asynchronously (mid-cycle) after 2 of 4 costs -> outputs immediately 0; after release, a fresh pixel [4, 2] gives d = 1, cost 2.
